// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mips_multicycle_ctrl
// Brief  : Multicycle MIPS control FSM driving datapath enables and ALU codes.
// Rev    : 1.0  initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int CNT_W           = 32,
    parameter int TRAP_ON_ILLEGAL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [3:0]       alu_control,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             imm_zext,
    output logic [1:0]       pc_src,
    output logic             pc_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_EXEC   = 4'd3,
        S_ALUWB  = 4'd4,  S_MEMADR = 4'd5,  S_MEMRD  = 4'd6,  S_MEMWB  = 4'd7,
        S_MEMWR  = 4'd8,  S_BRANCH = 4'd9,  S_IEXEC  = 4'd10, S_IWB    = 4'd11,
        S_LUIEX  = 4'd12, S_JUMP   = 4'd13, S_TRAP   = 4'd14
    } state_t;

    localparam logic [3:0] c_alu_and = 4'b0000;
    localparam logic [3:0] c_alu_or  = 4'b0001;
    localparam logic [3:0] c_alu_add = 4'b0010;
    localparam logic [3:0] c_alu_sub = 4'b0110;
    localparam logic [3:0] c_alu_slt = 4'b0111;
    localparam logic [3:0] c_alu_nor = 4'b1100;
    localparam logic [3:0] c_alu_lui = 4'b0011;

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam state_t c_bad_dest = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic             w_retire;
    logic             w_funct_ok;
    logic [3:0]       w_r_alu;
    logic [3:0]       w_i_alu;

    always_comb begin
        w_funct_ok = 1'b1;
        w_r_alu    = c_alu_add;
        case (funct)
            6'h20:   w_r_alu = c_alu_add;
            6'h22:   w_r_alu = c_alu_sub;
            6'h24:   w_r_alu = c_alu_and;
            6'h25:   w_r_alu = c_alu_or;
            6'h27:   w_r_alu = c_alu_nor;
            6'h2A:   w_r_alu = c_alu_slt;
            default: w_funct_ok = 1'b0;
        endcase
        case (opcode)
            6'h0C:   w_i_alu = c_alu_and;
            6'h0D:   w_i_alu = c_alu_or;
            6'h0A:   w_i_alu = c_alu_slt;
            default: w_i_alu = c_alu_add;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_count <= r_count + c_one;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        alu_control = c_alu_and;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        imm_zext    = 1'b0;
        pc_src      = 2'b00;
        pc_write    = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem_read    = 1'b1;
                alu_src_b   = 2'b01;
                alu_control = c_alu_add;
                pc_write    = mem_ready;
                ir_write    = mem_ready;
                if (mem_ready)
                    w_next = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively form the branch target so BRANCH can load it from ALUOut.
                alu_src_b   = 2'b11;
                alu_control = c_alu_add;
                case (opcode)
                    6'h00:                      w_next = S_EXEC;
                    6'h23, 6'h2B:               w_next = S_MEMADR;
                    6'h04, 6'h05:               w_next = S_BRANCH;
                    6'h08, 6'h0C, 6'h0D, 6'h0A: w_next = S_IEXEC;
                    6'h0F:                      w_next = S_LUIEX;
                    6'h02:                      w_next = S_JUMP;
                    default: begin
                        w_next   = c_bad_dest;
                        w_retire = (TRAP_ON_ILLEGAL == 0);
                    end
                endcase
            end
            S_EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = w_r_alu;
                w_next      = w_funct_ok ? S_ALUWB : c_bad_dest;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = c_alu_add;
                w_next      = (opcode == 6'h2B) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready)
                    w_next = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                w_retire  = mem_ready;
                if (mem_ready)
                    w_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = c_alu_sub;
                pc_src      = 2'b01;
                pc_write    = (opcode == 6'h04) ? zero : ~zero;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_IEXEC: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = w_i_alu;
                imm_zext    = (opcode == 6'h0C) || (opcode == 6'h0D);
                w_next      = S_IWB;
            end
            S_IWB: begin
                reg_write = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_LUIEX: begin
                alu_src_b   = 2'b10;
                alu_control = c_alu_lui;
                w_next      = S_IWB;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_TRAP: illegal = 1'b1;
            default: w_next = S_IDLE;
        endcase
    end

    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_mips_multicycle_ctrl
// Brief  : Instruction-level expectation model with per-cycle output compare.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] alu;
        logic       sa;
        logic [1:0] sb;
        logic       zx;
        logic [1:0] ps;
        logic       pw;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       rd;
        logic       m2r;
        logic       rw;
        logic       ill;
    } ov_t;

    typedef struct packed {
        ov_t         ov;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a_n = 1'b0;
    logic        rst_b_n = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;

    logic [3:0]  a_alu, b_alu;
    logic        a_sa, b_sa, a_zx, b_zx, a_pw, b_pw, a_iord, b_iord, a_mr, b_mr;
    logic        a_mw, b_mw, a_irw, b_irw, a_rd, b_rd, a_m2r, b_m2r, a_rw, b_rw, a_ill, b_ill;
    logic [1:0]  a_sb, b_sb, a_ps, b_ps;
    logic [31:0] a_cnt;
    logic [2:0]  b_cnt;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.CNT_W(32), .TRAP_ON_ILLEGAL(1)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_control(a_alu), .alu_src_a(a_sa), .alu_src_b(a_sb),
        .imm_zext(a_zx), .pc_src(a_ps), .pc_write(a_pw), .iord(a_iord), .mem_read(a_mr),
        .mem_write(a_mw), .ir_write(a_irw), .reg_dst(a_rd), .mem_to_reg(a_m2r),
        .reg_write(a_rw), .illegal(a_ill), .instr_count(a_cnt)
    );

    mips_multicycle_ctrl #(.CNT_W(3), .TRAP_ON_ILLEGAL(0)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_control(b_alu), .alu_src_a(b_sa), .alu_src_b(b_sb),
        .imm_zext(b_zx), .pc_src(b_ps), .pc_write(b_pw), .iord(b_iord), .mem_read(b_mr),
        .mem_write(b_mw), .ir_write(b_irw), .reg_dst(b_rd), .mem_to_reg(b_m2r),
        .reg_write(b_rw), .illegal(b_ill), .instr_count(b_cnt)
    );

    ov_t         ov_a, ov_b, act_ov;
    logic [31:0] act_cnt;
    logic        sel = 1'b0;

    assign ov_a = {a_alu, a_sa, a_sb, a_zx, a_ps, a_pw, a_iord, a_mr, a_mw, a_irw, a_rd, a_m2r, a_rw, a_ill};
    assign ov_b = {b_alu, b_sa, b_sb, b_zx, b_ps, b_pw, b_iord, b_mr, b_mw, b_irw, b_rd, b_m2r, b_rw, b_ill};
    assign act_ov  = sel ? ov_b : ov_a;
    assign act_cnt = sel ? {29'd0, b_cnt} : a_cnt;

    exp_t        q[$];
    exp_t        ce;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_cnt  = '0;
    logic [31:0] m_mask = 32'hFFFF_FFFF;
    logic [5:0]  cur_op = '0;
    logic [5:0]  cur_fn = '0;
    logic        cur_z  = 1'b0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            ce = q.pop_front();
            checks++;
            if (act_ov !== ce.ov) begin
                errors++;
                $display("FAIL outputs t=%0t actual=%h required=%h", $time, act_ov, ce.ov);
            end
            checks++;
            if (act_cnt !== ce.cnt) begin
                errors++;
                $display("FAIL instr_count t=%0t actual=%0d required=%0d", $time, act_cnt, ce.cnt);
            end
        end
    end

    function automatic logic [3:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h20:   return 4'b0010;
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h27:   return 4'b1100;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic logic [3:0] i_alu(input logic [5:0] op);
        case (op)
            6'h0C:   return 4'b0000;
            6'h0D:   return 4'b0001;
            6'h0A:   return 4'b0111;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic logic op_known(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) ||
               (op == 6'h05) || (op == 6'h08) || (op == 6'h0C) || (op == 6'h0D) ||
               (op == 6'h0A) || (op == 6'h0F) || (op == 6'h02);
    endfunction

    function automatic ov_t o_fetch(input logic rdy);
        ov_t o = '0;
        o.mr = 1'b1; o.sb = 2'b01; o.alu = 4'b0010; o.pw = rdy; o.irw = rdy;
        return o;
    endfunction

    task automatic cyc(input ov_t o, input logic rdy, input logic ret);
        exp_t e;
        @(posedge clk); #1;
        opcode = cur_op; funct = cur_fn; zero = cur_z; mem_ready = rdy;
        e.ov = o; e.cnt = m_cnt;
        q.push_back(e);
        if (ret) m_cnt = (m_cnt + 32'd1) & m_mask;
    endtask

    // Reset changes are applied mid-cycle so assertion is seen asynchronously.
    task automatic rst_cyc(input logic a, input logic b);
        exp_t e;
        @(posedge clk); #1;
        rst_a_n = a; rst_b_n = b; mem_ready = 1'b0;
        m_cnt = '0;
        e.ov = '0; e.cnt = m_cnt;
        q.push_back(e);
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
        #1;
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fw, input int mw);
        ov_t o;
        cur_op = op; cur_fn = fn; cur_z = z;
        for (int i = 0; i < fw; i++) cyc(o_fetch(1'b0), 1'b0, 1'b0);
        cyc(o_fetch(1'b1), 1'b1, 1'b0);
        o = '0; o.sb = 2'b11; o.alu = 4'b0010;
        cyc(o, 1'b1, !op_known(op) && sel);
        o = '0;
        case (op)
            6'h00: begin
                o.sa = 1'b1; o.alu = r_alu(fn); cyc(o, 1'b0, 1'b0);
                o = '0; o.rd = 1'b1; o.rw = 1'b1; cyc(o, 1'b0, 1'b1);
            end
            6'h23, 6'h2B: begin
                o.sa = 1'b1; o.sb = 2'b10; o.alu = 4'b0010; cyc(o, 1'b0, 1'b0);
                o = '0; o.iord = 1'b1;
                if (op == 6'h23) o.mr = 1'b1; else o.mw = 1'b1;
                for (int i = 0; i < mw; i++) cyc(o, 1'b0, 1'b0);
                cyc(o, 1'b1, op == 6'h2B);
                if (op == 6'h23) begin
                    o = '0; o.m2r = 1'b1; o.rw = 1'b1; cyc(o, 1'b0, 1'b1);
                end
            end
            6'h04, 6'h05: begin
                o.sa = 1'b1; o.alu = 4'b0110; o.ps = 2'b01;
                o.pw = (op == 6'h04) ? z : ~z;
                cyc(o, 1'b0, 1'b1);
            end
            6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h0F: begin
                if (op == 6'h0F) begin
                    o.sb = 2'b10; o.alu = 4'b0011;
                end else begin
                    o.sa = 1'b1; o.sb = 2'b10; o.alu = i_alu(op);
                    o.zx = (op == 6'h0C) || (op == 6'h0D);
                end
                cyc(o, 1'b0, 1'b0);
                o = '0; o.rw = 1'b1; cyc(o, 1'b0, 1'b1);
            end
            6'h02: begin
                o.ps = 2'b10; o.pw = 1'b1; cyc(o, 1'b0, 1'b1);
            end
            default: begin
                if (!sel) begin
                    o.ill = 1'b1;
                    for (int i = 0; i < 5; i++) cyc(o, i[0], 1'b0);
                end
            end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        ov_t o;
        rst_cyc(1'b0, 1'b0);
        rst_cyc(1'b1, 1'b0);
        run(6'h00, 6'h20, 1'b0, 0, 0);
        cyc(o_fetch(1'b0), 1'b0, 1'b0);
        lit("cnt_after_add", a_cnt, 32'd1);
        run(6'h23, 6'h00, 1'b0, 2, 3);
        run(6'h04, 6'h00, 1'b1, 0, 0);
        run(6'h05, 6'h00, 1'b1, 0, 0);
        run(6'h05, 6'h00, 1'b0, 0, 0);
        run(6'h04, 6'h00, 1'b0, 0, 0);
        run(6'h0D, 6'h00, 1'b0, 0, 0);
        run(6'h0C, 6'h00, 1'b0, 0, 0);
        run(6'h08, 6'h00, 1'b0, 0, 0);
        run(6'h0A, 6'h00, 1'b0, 0, 0);
        run(6'h0F, 6'h00, 1'b0, 0, 0);
        run(6'h00, 6'h22, 1'b0, 0, 0);
        run(6'h00, 6'h24, 1'b0, 0, 0);
        run(6'h00, 6'h25, 1'b0, 0, 0);
        run(6'h00, 6'h27, 1'b0, 0, 0);
        run(6'h00, 6'h2A, 1'b0, 0, 0);
        run(6'h2B, 6'h00, 1'b0, 0, 2);
        run(6'h02, 6'h00, 1'b0, 0, 0);
        cyc(o_fetch(1'b0), 1'b0, 1'b0);
        lit("cnt_after_18", a_cnt, 32'd18);
        // Store interrupted by reset while waiting in the write phase.
        cur_op = 6'h2B; cur_fn = 6'h00;
        cyc(o_fetch(1'b1), 1'b1, 1'b0);
        o = '0; o.sb = 2'b11; o.alu = 4'b0010; cyc(o, 1'b0, 1'b0);
        o = '0; o.sa = 1'b1; o.sb = 2'b10; o.alu = 4'b0010; cyc(o, 1'b0, 1'b0);
        o = '0; o.mw = 1'b1; o.iord = 1'b1; cyc(o, 1'b0, 1'b0);
        rst_cyc(1'b0, 1'b0);
        rst_cyc(1'b1, 1'b0);
        run(6'h00, 6'h20, 1'b0, 0, 0);
        run(6'h3F, 6'h00, 1'b0, 0, 0);
        lit("trap_illegal", {31'd0, a_ill}, 32'd1);
        lit("trap_cnt_frozen", a_cnt, 32'd1);
        // Second instance: illegal opcodes as NOPs and a 3-bit wrapping counter.
        rst_cyc(1'b0, 1'b0);
        sel = 1'b1;
        m_mask = 32'd7;
        rst_cyc(1'b0, 1'b1);
        run(6'h3F, 6'h00, 1'b0, 0, 0);
        cyc(o_fetch(1'b0), 1'b0, 1'b0);
        lit("nop_cnt", {29'd0, b_cnt}, 32'd1);
        for (int i = 0; i < 7; i++) run(6'h00, 6'h20, 1'b0, 0, 0);
        cyc(o_fetch(1'b0), 1'b0, 1'b0);
        lit("wrap_cnt", {29'd0, b_cnt}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
